// File: rtl/bus_arbiter_8.sv
// Eight-way round-robin bus arbiter with registered one-hot grant, owner index
// and a hold timer that forces rotation when an owner keeps the bus under contention.
module bus_arbiter_8 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt,
  output logic       state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Saturation point of the hold counter; pinned at 0 when preemption is disabled.
  localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  // Handshake: req[i] is a level held by requester i until it is done; grant[i]
  // is the registered answer and stays high while req[i] stays high, unless the
  // hold timer hands the bus to another waiting requester.

  logic [0:0] state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] grant_q;
  logic       preempt_q, preempt_d;
  logic [7:0] others;
  logic [3:0] pick_all, pick_oth;

  // Returns {found, index} of the first set bit at or after start, wrapping 7->0.
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    others    = req & ~(8'b1 << owner_q);
    pick_all  = rr_pick(req, last_q + 3'd1);
    pick_oth  = rr_pick(others, last_q + 3'd1);
    case (state_q)
      IDLE: begin
        if (pick_all[3]) begin
          state_d = GRANT;
          owner_d = pick_all[2:0];
          last_d  = pick_all[2:0];
          hold_d  = 8'd0;
        end
      end
      default: begin
        if (!req[owner_q]) begin
          if (pick_oth[3]) begin
            owner_d = pick_oth[2:0];
            last_d  = pick_oth[2:0];
            hold_d  = 8'd0;
          end else begin
            state_d = IDLE;
            owner_d = 3'd0;
            hold_d  = 8'd0;
          end
        end else if ((HOLD_MAX != 0) && (hold_q == HOLD_LAST) && pick_oth[3]) begin
          owner_d   = pick_oth[2:0];
          last_d    = pick_oth[2:0];
          hold_d    = 8'd0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 3'd0;
      last_q    <= 3'd7;
      hold_q    <= 8'd0;
      grant_q   <= 8'd0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      grant_q   <= (state_d == GRANT) ? (8'b1 << owner_d) : 8'd0;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = owner_q;
  assign grant_valid = (state_q == GRANT);
  assign preempt     = preempt_q;
  assign state       = state_q;

endmodule

// File: doc/bus_arbiter_8.md
# bus_arbiter_8

Round-robin arbiter sharing one resource, such as the emulator's shared data bus or memory port, between eight requesters. It produces a registered one-hot grant, the same encoding the 8-output decoder produces from a 3-bit select, plus the binary owner index. A hold timer lets the arbiter preempt an owner that keeps the resource while others are waiting. It sits between the requesting units and the bus-select decoder/mux.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive grant cycles before forced rotation when others are waiting. Valid range 0..255; 0 disables preemption.
- `clk`  in  1: clock, rising edge active.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `req`  in  8: per-requester level request. `req[i]` = 1 means requester i wants the bus.
- `grant`  out  8: one-hot grant, registered; all-zero when idle.
- `grant_idx`  out  3: binary index of the current owner; 0 when idle.
- `grant_valid`  out  1: 1 when `grant` is non-zero.
- `preempt`  out  1: one-cycle pulse on the cycle a grant begins as the result of a forced rotation.

## Operation
- **Reset values:** one clock, reset asynchronous and active-low. While `reset_n` = 0:
  - `grant`=0, `grant_idx`=0, `grant_valid`=0, `preempt`=0.
  - state=IDLE, pointer `last`=7, `hold_cnt`=0.
- **Search order:** starts at (`last`+1) mod 8, ascending, wrapping 7→0. The first set bit wins. After reset, index 0 therefore has highest priority.
- **States:**
  - IDLE:
    - If any `req` bit is set at a clock edge, go to GRANT with the winning owner. Set `last`=owner and `hold_cnt`=0.
    - Otherwise stay in IDLE.
  - GRANT, evaluated at each edge with owner o:
    - **Release:** `req[o]`=0. Search the other requests, excluding o. If a winner exists, grant it immediately with no idle gap and `preempt`=0. Otherwise go to IDLE and clear all outputs.
    - **Preempt:** `req[o]`=1, `HOLD_MAX`≠0, `hold_cnt` = `HOLD_MAX`-1, and at least one other `req` is set. Grant the next requester in search order and pulse `preempt`=1 for that cycle.
    - **Otherwise:** keep o. `hold_cnt` increments and saturates at `HOLD_MAX`-1. With `HOLD_MAX`=0 it stays at 0.
- **New grant:** every new grant, including a re-grant of the same index after an idle gap, sets `hold_cnt`=0 and `last`=new owner.
- **Output invariants:** `grant` is always zero or one-hot; `grant_idx` always matches `grant`.
- **Widths:** `hold_cnt` is 8 bits. The comparison against `HOLD_MAX`-1 is evaluated only when `HOLD_MAX`≠0, so no underflow occurs.

## Timing
- All outputs are registered and update only on the rising edge of `clk`, except for the asynchronous reset.
- **Request latency:** `req` set before edge n gives the grant visible after edge n. That is one cycle from an idle state.
- **Handover:** the owner drops `req` before edge k. At edge k the grant moves directly to the next requester; no dead cycle.
- **Preemption:** with continuous contention, an owner holds the grant for exactly `HOLD_MAX` cycles. `preempt` is high for exactly 1 cycle, aligned with the new `grant`.
- **Simultaneous events:** the owner releasing on the same edge its hold expires is treated as a release, so `preempt`=0.
- **New requests:** a `req` bit rising on the same edge the owner releases is eligible in that edge's search.
- **Reset mid-grant:** outputs clear immediately, without waiting for a clock edge. After `reset_n` rises, the first grant follows the post-reset priority (`last`=7).
- **Glitches:** `req` pulses shorter than one cycle and not present at an edge are ignored.

## Test plan
1. **Reset state:** assert `reset_n`=0 while `req`=8'hFF.
   - `grant`=8'h00, `grant_valid`=0, `preempt`=0 throughout.
   - Release reset: the first edge gives `grant`=8'b00000001, `grant_idx`=0.
2. **Single request:** from IDLE, set `req`=8'b00001000.
   - One edge later: `grant`=8'b00001000, `grant_idx`=3.
   - Clear `req`: the next edge gives `grant`=0, `grant_valid`=0.
3. **Round-robin and wrap:** with `HOLD_MAX`=0, set `req`=8'b10000011, and each owner drops its `req` one cycle after being granted, then reasserts it.
   - Grant order is 0, 1, 7, 0, with no idle cycle between owners.
4. **Preemption:** with `HOLD_MAX`=4, hold `req`=8'b00000101 constant.
   - Grant 0 lasts 4 cycles, then grant 2 lasts 4 cycles, then back to 0.
   - `preempt`=1 on each switch cycle only.
5. **No contention:** with `HOLD_MAX`=4, hold `req`=8'b00010000 for 20 cycles.
   - `grant` stays 8'b00010000 and `preempt` stays 0.
6. **Reset mid-operation:** drop `reset_n` asynchronously between edges while grant 5 is active.
   - `grant` goes to 0 before the next edge.
   - After release with `req`=8'b00100001, the first grant is index 0.
